// File: rtl/logic_cond_monitor.sv
// ---------------------------------------------------------------------------
// logic_cond_monitor
//
// Response-side checker for logic-conditional regression benches. Samples
// (stimulus, DUT result, expected result) arrive over a valid/ready
// handshake and are compared bit by bit with 4-state case inequality.
// Mismatching samples and samples whose result carries any x/z bit are
// counted (saturating). Every mismatch is recorded in a small
// first-word-fall-through log FIFO for later readout.
//
// Build option:
//   LOGIC_COND_MON_WILDCARD_EN
//     defined   : x/z bits of exp_out are don't-cares.
//     undefined : strict case inequality on every bit.
//
// Parameters:
//   WIDTH    bits per sample
//   DEPTH    mismatch log entries (power of two, >= 2)
//   COUNT_W  width of the sample index and of the counters
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   start      begin a run (IDLE/DONE -> RUN), clears counters and log
//   smp_valid  sample offered
//   smp_ready  sample accepted when high together with smp_valid
//   smp_inp    stimulus value (logged only)
//   smp_out    DUT result
//   exp_out    expected result
//   smp_last   final sample of the run
//   busy       state is RUN
//   done       state is DONE
//   pass       done with no mismatches
//   mism_count mismatching samples (saturating)
//   xz_count   samples whose smp_out has any x/z bit (saturating)
//   log_valid  log non-empty
//   log_ready  pop the log head
//   log_idx    sample index of the log head
//   log_inp    recorded smp_inp of the log head
//   log_got    recorded smp_out of the log head
//   log_exp    recorded exp_out of the log head
// ---------------------------------------------------------------------------
module logic_cond_monitor #(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               smp_valid,
    output logic               smp_ready,
    input  logic [WIDTH-1:0]   smp_inp,
    input  logic [WIDTH-1:0]   smp_out,
    input  logic [WIDTH-1:0]   exp_out,
    input  logic               smp_last,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] mism_count,
    output logic [COUNT_W-1:0] xz_count,
    output logic               log_valid,
    input  logic               log_ready,
    output logic [COUNT_W-1:0] log_idx,
    output logic [WIDTH-1:0]   log_inp,
    output logic [WIDTH-1:0]   log_got,
    output logic [WIDTH-1:0]   log_exp
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Comparison helpers. No 2-state coercion anywhere: a result is x/z-tainted
    // when its reduction-XOR is neither a clean 0 nor a clean 1.
    // -----------------------------------------------------------------------
    function automatic logic f_mismatch(input logic [WIDTH-1:0] got,
                                        input logic [WIDTH-1:0] exp);
        logic m;
        m = 1'b0;
`ifdef LOGIC_COND_MON_WILDCARD_EN
        for (int i = 0; i < WIDTH; i++) begin
            // Only bits with a known expected value take part in the compare.
            if ((exp[i] === 1'b0) || (exp[i] === 1'b1)) begin
                if (got[i] !== exp[i]) begin
                    m = 1'b1;
                end else begin
                    m = m;
                end
            end else begin
                m = m;
            end
        end
`else
        if (got !== exp) begin
            m = 1'b1;
        end else begin
            m = 1'b0;
        end
`endif
        return m;
    endfunction

    function automatic logic f_has_xz(input logic [WIDTH-1:0] v);
        logic p;
        p = ^v;
        return (p !== 1'b0) && (p !== 1'b1);
    endfunction

    // -----------------------------------------------------------------------
    // State and storage
    // -----------------------------------------------------------------------
    state_t             state_r;
    state_t             state_nxt_s;
    logic [COUNT_W-1:0] idx_r;
    logic [COUNT_W-1:0] mism_r;
    logic [COUNT_W-1:0] xz_r;
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;

    logic [COUNT_W-1:0] mem_idx_r [DEPTH];
    logic [WIDTH-1:0]   mem_inp_r [DEPTH];
    logic [WIDTH-1:0]   mem_got_r [DEPTH];
    logic [WIDTH-1:0]   mem_exp_r [DEPTH];

    logic busy_s;
    logic log_full_s;
    logic log_empty_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic mism_s;
    logic xz_s;
    logic run_clear_s;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign log_empty_s = (wr_ptr_r == rd_ptr_r);
    assign log_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign busy_s    = (state_r == ST_RUN);
    assign smp_ready = busy_s && !log_full_s;
    assign accept_s  = smp_valid && smp_ready;
    assign mism_s    = f_mismatch(smp_out, exp_out);
    assign xz_s      = f_has_xz(smp_out);
    assign push_s    = accept_s && mism_s;
    assign pop_s     = !log_empty_s && log_ready;

    // start is honoured only outside RUN; it opens a fresh run.
    assign run_clear_s = start && (state_r != ST_RUN);

    // Next-state decode for the IDLE/RUN/DONE controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && smp_last) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample index and saturating mismatch / x-z counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r  <= {COUNT_W{1'b0}};
            mism_r <= {COUNT_W{1'b0}};
            xz_r   <= {COUNT_W{1'b0}};
        end else if (run_clear_s) begin
            idx_r  <= {COUNT_W{1'b0}};
            mism_r <= {COUNT_W{1'b0}};
            xz_r   <= {COUNT_W{1'b0}};
        end else if (accept_s) begin
            // Index wraps naturally at 2^COUNT_W.
            idx_r <= idx_r + COUNT_W'(1);
            if (mism_s && (mism_r != {COUNT_W{1'b1}})) begin
                mism_r <= mism_r + COUNT_W'(1);
            end else begin
                mism_r <= mism_r;
            end
            if (xz_s && (xz_r != {COUNT_W{1'b1}})) begin
                xz_r <= xz_r + COUNT_W'(1);
            end else begin
                xz_r <= xz_r;
            end
        end else begin
            idx_r  <= idx_r;
            mism_r <= mism_r;
            xz_r   <= xz_r;
        end
    end

    // Log FIFO pointers; a simultaneous push and pop leaves the fill unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (run_clear_s) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Log storage, cleared on reset so the head reads 0 until the first push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_idx_r[i] <= {COUNT_W{1'b0}};
                mem_inp_r[i] <= {WIDTH{1'b0}};
                mem_got_r[i] <= {WIDTH{1'b0}};
                mem_exp_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            // Raw 4-state values are stored so x/z reach the readout unchanged.
            mem_idx_r[wr_ptr_r[AW-1:0]] <= idx_r;
            mem_inp_r[wr_ptr_r[AW-1:0]] <= smp_inp;
            mem_got_r[wr_ptr_r[AW-1:0]] <= smp_out;
            mem_exp_r[wr_ptr_r[AW-1:0]] <= exp_out;
        end else begin
            mem_idx_r <= mem_idx_r;
            mem_inp_r <= mem_inp_r;
            mem_got_r <= mem_got_r;
            mem_exp_r <= mem_exp_r;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded straight from registers (first-word fall-through
    // for the log head).
    // -----------------------------------------------------------------------
    assign busy       = busy_s;
    assign done       = (state_r == ST_DONE);
    assign pass       = (state_r == ST_DONE) && (mism_r == {COUNT_W{1'b0}});
    assign mism_count = mism_r;
    assign xz_count   = xz_r;
    assign log_valid  = !log_empty_s;
    assign log_idx    = mem_idx_r[rd_ptr_r[AW-1:0]];
    assign log_inp    = mem_inp_r[rd_ptr_r[AW-1:0]];
    assign log_got    = mem_got_r[rd_ptr_r[AW-1:0]];
    assign log_exp    = mem_exp_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_logic_cond_monitor.sv
// ---------------------------------------------------------------------------
// tb_logic_cond_monitor
//
// Directed bench for logic_cond_monitor (WIDTH=1, DEPTH=2, COUNT_W=3).
// A bench-side model tracks state, counters and the index; every logged
// mismatch is pushed to a scoreboard queue when the sample is accepted and
// popped/compared when the bench pops the DUT log. Inputs are driven on the
// falling edge, outputs checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_logic_cond_monitor;

    localparam int WIDTH   = 1;
    localparam int DEPTH   = 2;
    localparam int COUNT_W = 3;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               smp_valid;
    logic               smp_ready;
    logic [WIDTH-1:0]   smp_inp;
    logic [WIDTH-1:0]   smp_out;
    logic [WIDTH-1:0]   exp_out;
    logic               smp_last;
    logic               busy;
    logic               done;
    logic               pass;
    logic [COUNT_W-1:0] mism_count;
    logic [COUNT_W-1:0] xz_count;
    logic               log_valid;
    logic               log_ready;
    logic [COUNT_W-1:0] log_idx;
    logic [WIDTH-1:0]   log_inp;
    logic [WIDTH-1:0]   log_got;
    logic [WIDTH-1:0]   log_exp;

    logic_cond_monitor #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_inp    (smp_inp),
        .smp_out    (smp_out),
        .exp_out    (exp_out),
        .smp_last   (smp_last),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .mism_count (mism_count),
        .xz_count   (xz_count),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_idx    (log_idx),
        .log_inp    (log_inp),
        .log_got    (log_got),
        .log_exp    (log_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [COUNT_W-1:0] idx;
        logic               inp;
        logic               got;
        logic               exp;
    } rec_t;

    rec_t q[$];

    int compared = 0;
    int mismatched = 0;

    // Model state: 0 idle, 1 run, 2 done
    int                 m_state;
    logic [COUNT_W-1:0] m_idx;
    int                 m_mism;
    int                 m_xz;

    function automatic logic mdl_mism(input logic g, input logic e);
`ifdef LOGIC_COND_MON_WILDCARD_EN
        if ($isunknown(e)) return 1'b0;
`endif
        return (g !== e);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_idx  = '0;
        m_mism = 0;
        m_xz   = 0;
        q.delete();
    endtask

    // Compare every status output with the model (called on the falling edge).
    task automatic check_status();
        logic exp_ready;
        exp_ready = (m_state == 1) && (q.size() < DEPTH);
        chk("busy",       8'(busy),       8'(m_state == 1));
        chk("done",       8'(done),       8'(m_state == 2));
        chk("pass",       8'(pass),       8'((m_state == 2) && (m_mism == 0)));
        chk("smp_ready",  8'(smp_ready),  8'(exp_ready));
        chk("mism_count", 8'(mism_count), 8'(m_mism));
        chk("xz_count",   8'(xz_count),   8'(m_xz));
        chk("log_valid",  8'(log_valid),  8'(q.size() != 0));
    endtask

    // One clock cycle: check, drive, predict, advance to the next falling edge.
    task automatic cyc(input logic v, input logic i, input logic g, input logic e,
                       input logic l, input logic lr, input logic st, output logic acc);
        logic pop_e;
        logic mm;
        rec_t r;
        check_status();
        smp_valid = v;
        smp_inp   = i;
        smp_out   = g;
        exp_out   = e;
        smp_last  = l;
        log_ready = lr;
        start     = st;
        #1;
        acc   = v && (m_state == 1) && (q.size() < DEPTH);
        pop_e = (q.size() != 0) && lr;
        if (pop_e) begin
            chk("log_idx", 8'(log_idx), 8'(q[0].idx));
            chk("log_inp", 8'(log_inp), 8'(q[0].inp));
            chk("log_got", 8'(log_got), 8'(q[0].got));
            chk("log_exp", 8'(log_exp), 8'(q[0].exp));
        end
        if (st && (m_state != 1)) begin
            model_clear();
            m_state = 1;
            acc = 1'b0;
        end else begin
            if (pop_e) void'(q.pop_front());
            if (acc) begin
                mm = mdl_mism(g, e);
                if (mm) begin
                    r.idx = m_idx;
                    r.inp = i;
                    r.got = g;
                    r.exp = e;
                    q.push_back(r);
                    if (m_mism < 7) m_mism++;
                end
                if ($isunknown(g) && (m_xz < 7)) m_xz++;
                m_idx = m_idx + 3'd1;
                if (l) m_state = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic lr);
        logic acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lr, 1'b0, acc);
    endtask

    task automatic begin_run();
        logic acc;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    // Offer one sample until accepted, bounded.
    task automatic send(input logic i, input logic g, input logic e, input logic l,
                        input logic lr);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && (n < 20)) begin
            cyc(1'b1, i, g, e, l, lr, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            mismatched++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted");
        end
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        start     = 1'b0;
        smp_valid = 1'b0;
        smp_inp   = 1'b0;
        smp_out   = 1'b0;
        exp_out   = 1'b0;
        smp_last  = 1'b0;
        log_ready = 1'b0;
        m_state   = 0;
        model_clear();

        // Reset held two cycles; start during reset must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_log_idx", 8'(log_idx), 8'd0);
        chk("rst_log_inp", 8'(log_inp), 8'd0);
        chk("rst_log_got", 8'(log_got), 8'd0);
        chk("rst_log_exp", 8'(log_exp), 8'd0);

        // Idle: samples offered without start are never accepted.
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc);

        // Clean run (start inside RUN ignored).
        begin_run();
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1'bx, 1'bx, 1'bx, 1'b0, 1'b1);
        send(1'bx, 1'bx, 1'bx, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Mismatch run with continuous pops.
        begin_run();
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1'bx, 1'b0, 1'bx, 1'b0, 1'b1);
        send(1'b1, 1'bx, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Backpressure: fill the 2-entry log, stall, then pop to admit more.
        begin_run();
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Saturation and index wrap over 10 mismatching samples.
        begin_run();
        for (int k = 0; k < 10; k++) send(k[0], 1'b1, 1'b0, (k == 9), 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of a run.
        begin_run();
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        m_state = 0;
        model_clear();
        idle(2, 1'b0);

        // Wildcard expectation: got=1 against exp=x.
        begin_run();
        send(1'b0, 1'b1, 1'bx, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
